// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the buffered UART receiver.
// Holds the receive FSM state encoding and the end-of-string character set.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // CR and LF both terminate a command line.
    function automatic logic isEos(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

endpackage

// File: rtl/uart_rx_buffered_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every
// CLK_FREQ/(BAUD_RATE*OVERSAMPLING) clocks (integer truncation).
module uart_baud_tick #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLING = 16
) (
    input  logic clk_50mhz,
    input  logic rst,
    output logic tick
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DIV > 1) ? DIV - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling 8N1 UART receiver with line-occupancy counter and CR/LF detection.
// Define UART_RX_FRAMING_CHECK_EN to discard frames whose stop bit samples low.
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLING    = 16,
    parameter int RX_BUFFER_DEPTH = 32
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       eos_flag,
    output logic       buffer_full
);

    localparam int OCC_W  = $clog2(RX_BUFFER_DEPTH + 1);
    localparam int TCNT_W = $clog2(OVERSAMPLING);
    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [TCNT_W-1:0] BIT_LAST  = TCNT_W'(OVERSAMPLING - 1);
    localparam logic [OCC_W-1:0]  DEPTH     = OCC_W'(RX_BUFFER_DEPTH);

    logic baudTick;

    uart_baud_tick #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE),
        .OVERSAMPLING (OVERSAMPLING)
    ) uBaudTick (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .tick      (baudTick)
    );

    logic              sync1_q, sync2_q, prev_q;
    rxState_t          state_q, state_d;
    logic [TCNT_W-1:0] tickCnt_q, tickCnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        shift_q, shift_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [7:0]        rxData_q, rxData_d;
    logic              rxValid_q, rxValid_d;
    logic              eos_q, eos_d;
    logic              fallingEdge;
    logic              frameOk;

    // Synchronizer and edge-history flops idle high so release from reset is not an edge.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fallingEdge = prev_q & ~sync2_q;

`ifdef UART_RX_FRAMING_CHECK_EN
    assign frameOk = sync2_q;
`else
    assign frameOk = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        tickCnt_d = tickCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        occ_d     = occ_q;
        rxData_d  = rxData_q;
        rxValid_d = 1'b0;
        eos_d     = eos_q;

        case (state_q)
            IDLE: begin
                if (fallingEdge) begin
                    state_d   = START;
                    tickCnt_d = '0;
                end
            end

            START: begin
                if (baudTick) begin
                    if (tickCnt_q == HALF_LAST) begin
                        tickCnt_d = '0;
                        if (!sync2_q) begin
                            state_d  = DATA;
                            bitIdx_d = 3'd0;
                            eos_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (baudTick) begin
                    if (tickCnt_q == BIT_LAST) begin
                        tickCnt_d         = '0;
                        shift_d[bitIdx_q] = sync2_q;
                        if (bitIdx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bitIdx_d = bitIdx_q + 3'd1;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
            end

            STOP: begin
                // Leaving at mid-stop lets a start edge in the stop bit's second half be caught.
                if (baudTick) begin
                    if (tickCnt_q == BIT_LAST) begin
                        tickCnt_d = '0;
                        state_d   = IDLE;
                        if (frameOk) begin
                            if (isEos(shift_q)) begin
                                rxData_d  = shift_q;
                                rxValid_d = 1'b1;
                                occ_d     = '0;
                                eos_d     = 1'b1;
                            end else if (occ_q != DEPTH) begin
                                rxData_d  = shift_q;
                                rxValid_d = 1'b1;
                                occ_d     = occ_q + 1'b1;
                            end
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            bitIdx_q  <= 3'd0;
            shift_q   <= 8'h00;
            occ_q     <= '0;
            rxData_q  <= 8'h00;
            rxValid_q <= 1'b0;
            eos_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tickCnt_q <= tickCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            occ_q     <= occ_d;
            rxData_q  <= rxData_d;
            rxValid_q <= rxValid_d;
            eos_q     <= eos_d;
        end
    end

    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign eos_flag    = eos_q;
    assign buffer_full = (occ_q == DEPTH);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered; clock scaled so the divider is 4 (64 clocks per bit).
// Expectations follow UART_RX_FRAMING_CHECK_EN when it is defined for the build.
module tb_uart_rx_buffered;

    localparam int CLK_FREQ = 7_372_800;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int DEPTH    = 32;
    localparam int BIT_CLKS = 64;

    logic       clk_50mhz = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       eos_flag;
    logic       buffer_full;

    int total = 0;
    int bad = 0;
    int validCount = 0;
    int base;

    uart_rx_buffered #(
        .CLK_FREQ        (CLK_FREQ),
        .BAUD_RATE       (BAUD),
        .OVERSAMPLING    (OS),
        .RX_BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .eos_flag    (eos_flag),
        .buffer_full (buffer_full)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        if (rx_valid === 1'b1) validCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic driveBit(input logic v);
        rx_in = v;
        waitClocks(BIT_CLKS);
    endtask

    task automatic sendTail(input logic [7:0] b, input logic stopBit);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
        driveBit(stopBit);
        rx_in = 1'b1;
        waitClocks(8);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        driveBit(1'b0);
        sendTail(b, stopBit);
    endtask

    initial begin
        rx_in = 1'b1;
        rst   = 1'b1;
        waitClocks(5);
        checkOutput("reset_data", rx_data, 0);
        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_eos", eos_flag, 0);
        checkOutput("reset_full", buffer_full, 0);
        rst = 1'b0;
        waitClocks(20);

        base = validCount;
        applyStimulus(8'h55, 1'b1);
        checkOutput("b55_pulses", validCount - base, 1);
        checkOutput("b55_data", rx_data, 32'h55);
        checkOutput("b55_eos", eos_flag, 0);
        checkOutput("b55_full", buffer_full, 0);

        rst = 1'b1;
        waitClocks(3);
        rst = 1'b0;
        waitClocks(10);

        base = validCount;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(8'(8'h10 + i), 1'b1);
            if (i == 30) checkOutput("fill31_not_full", buffer_full, 0);
        end
        checkOutput("fill_pulses", validCount - base, 32);
        checkOutput("fill_data", rx_data, 32'h2F);
        checkOutput("fill_full", buffer_full, 1);

        base = validCount;
        applyStimulus(8'hFF, 1'b1);
        checkOutput("drop_pulses", validCount - base, 0);
        checkOutput("drop_data", rx_data, 32'h2F);
        checkOutput("drop_full", buffer_full, 1);

        base = validCount;
        applyStimulus(8'h0D, 1'b1);
        checkOutput("cr_pulses", validCount - base, 1);
        checkOutput("cr_data", rx_data, 32'h0D);
        checkOutput("cr_eos", eos_flag, 1);
        checkOutput("cr_full", buffer_full, 0);

        base = validCount;
        driveBit(1'b0);
        checkOutput("aa_eos_at_start", eos_flag, 0);
        sendTail(8'hAA, 1'b1);
        checkOutput("aa_pulses", validCount - base, 1);
        checkOutput("aa_data", rx_data, 32'hAA);

        for (int i = 0; i < 30; i++) applyStimulus(8'(8'h61 + i), 1'b1);
        checkOutput("occ31_not_full", buffer_full, 0);
        applyStimulus(8'h7F, 1'b1);
        checkOutput("occ32_full", buffer_full, 1);

        applyStimulus(8'h0A, 1'b1);
        checkOutput("lf_data", rx_data, 32'h0A);
        checkOutput("lf_eos", eos_flag, 1);
        checkOutput("lf_full", buffer_full, 0);

        base = validCount;
        rx_in = 1'b0;
        waitClocks(3 * BIT_CLKS / 16);
        rx_in = 1'b1;
        waitClocks(3 * BIT_CLKS);
        checkOutput("glitch_pulses", validCount - base, 0);
        checkOutput("glitch_data", rx_data, 32'h0A);
        checkOutput("glitch_eos", eos_flag, 1);

        base = validCount;
        applyStimulus(8'h5A, 1'b1);
        checkOutput("post_glitch_pulses", validCount - base, 1);
        checkOutput("post_glitch_data", rx_data, 32'h5A);
        checkOutput("post_glitch_eos", eos_flag, 0);

        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        rst   = 1'b1;
        rx_in = 1'b1;
        waitClocks(3);
        checkOutput("midrst_data", rx_data, 0);
        checkOutput("midrst_valid", rx_valid, 0);
        checkOutput("midrst_eos", eos_flag, 0);
        checkOutput("midrst_full", buffer_full, 0);
        rst = 1'b0;
        waitClocks(2 * BIT_CLKS);
        base = validCount;
        applyStimulus(8'hC3, 1'b1);
        checkOutput("after_rst_pulses", validCount - base, 1);
        checkOutput("after_rst_data", rx_data, 32'hC3);

        base = validCount;
        applyStimulus(8'h41, 1'b0);
        waitClocks(BIT_CLKS);
`ifdef UART_RX_FRAMING_CHECK_EN
        checkOutput("frame_err_pulses", validCount - base, 0);
        checkOutput("frame_err_data", rx_data, 32'hC3);
`else
        checkOutput("frame_err_pulses", validCount - base, 1);
        checkOutput("frame_err_data", rx_data, 32'h41);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
